// File: rtl/fetch_prefetch_queue_if.sv
// Prefetch queue bus: instruction-memory read port and fetch-side byte window.
// master = prefetch queue, slave = memory/fetch environment.
interface fetch_prefetch_queue_if;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [63:0] imem_rdata;
    logic        imem_err;
    logic [79:0] inst_bytes;
    logic [3:0]  avail;
    logic [63:0] head_pc;
    logic        consume;
    logic [3:0]  consume_len;
    logic        inst_err;

    modport master (
        input  redirect, redirect_pc,
        input  imem_rvalid, imem_rdata, imem_err,
        input  consume, consume_len,
        output imem_req, imem_addr,
        output inst_bytes, avail, head_pc, inst_err
    );

    modport slave (
        output redirect, redirect_pc,
        output imem_rvalid, imem_rdata, imem_err,
        output consume, consume_len,
        input  imem_req, imem_addr,
        input  inst_bytes, avail, head_pc, inst_err
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Byte-stream instruction prefetcher: issues aligned 8-byte reads and
// presents up to 10 contiguous bytes at head_pc to the fetch stage.
// Ports: clk, reset (async, active-high), bus (fetch_prefetch_queue_if.master).
module fetch_prefetch_queue #(
    parameter int unsigned QBYTES   = 16,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic                    clk,
    input logic                    reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(QBYTES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state;
    logic [7:0]    qbuf [QBYTES];
    logic [PW-1:0] head_ptr;
    logic [CW-1:0] count;
    logic [63:0]   head_pc;
    logic [63:0]   fetch_addr;
    logic [63:0]   req_addr;
    logic [2:0]    drop_off;
    logic          err;
    logic          req;

    logic [PW-1:0] tail_ptr;
    logic [3:0]    avail;
    logic [3:0]    cons_n;
    logic [3:0]    wr_n;
    logic [CW-1:0] count_after;
    logic          do_consume;
    logic          do_write;
    logic          outstanding;
    logic          space_ok;
    logic [79:0]   win;

    always_comb begin
        avail       = (count >= CW'(10)) ? 4'd10 : count[3:0];
        tail_ptr    = head_ptr + count[PW-1:0];
        do_consume  = bus.consume && !bus.redirect
                      && (bus.consume_len != 4'd0)
                      && (bus.consume_len <= avail);
        cons_n      = do_consume ? bus.consume_len : 4'd0;
        do_write    = (state == WAIT) && bus.imem_rvalid
                      && !bus.imem_err && !bus.redirect;
        wr_n        = do_write ? (4'd8 - {1'b0, drop_off}) : 4'd0;
        count_after = count - CW'(cons_n);
        // 8 bytes stay reserved so the response always fits.
        space_ok    = count_after <= CW'(QBYTES - 8);
        // A response still owed by memory must be swallowed after redirect.
        outstanding = ((state == WAIT) || (state == DROP))
                      && !bus.imem_rvalid;
    end

    always_comb begin
        win = '0;
        for (int k = 0; k < 10; k++) begin
            win[8*k +: 8] = qbuf[head_ptr + PW'(k)];
        end
    end

    assign bus.inst_bytes = win;
    assign bus.avail      = avail;
    assign bus.head_pc    = head_pc;
    assign bus.inst_err   = err;
    assign bus.imem_req   = req;
    assign bus.imem_addr  = req_addr;

    // Bytes below drop_off precede the head after an unaligned redirect.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) >= drop_off) begin
                    qbuf[tail_ptr + PW'(i) - PW'(drop_off)]
                        <= bus.imem_rdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            head_ptr   <= '0;
            count      <= '0;
            head_pc    <= RESET_PC;
            fetch_addr <= {RESET_PC[63:3], 3'b000};
            drop_off   <= RESET_PC[2:0];
            err        <= 1'b0;
            req        <= 1'b0;
            req_addr   <= '0;
        end else begin
            req <= 1'b0;
            if (bus.redirect) begin
                count      <= '0;
                err        <= 1'b0;
                head_ptr   <= '0;
                head_pc    <= bus.redirect_pc;
                fetch_addr <= {bus.redirect_pc[63:3], 3'b000};
                drop_off   <= bus.redirect_pc[2:0];
                state      <= outstanding ? DROP : IDLE;
            end else begin
                head_pc  <= head_pc + 64'(cons_n);
                head_ptr <= head_ptr + PW'(cons_n);
                count    <= count_after + CW'(wr_n);
                unique case (state)
                    IDLE: begin
                        if (!err && space_ok) begin
                            req      <= 1'b1;
                            req_addr <= fetch_addr;
                            state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.imem_rvalid) begin
                            state <= IDLE;
                            if (bus.imem_err) begin
                                err <= 1'b1;
                            end else begin
                                drop_off   <= 3'd0;
                                fetch_addr <= fetch_addr + 64'd8;
                            end
                        end
                    end
                    DROP: begin
                        if (bus.imem_rvalid) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed scenarios plus
// randomized redirect/consume traffic against a byte-stream reference model.
module tb_fetch_prefetch_queue;
    localparam int QB = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if bus ();

    fetch_prefetch_queue #(
        .QBYTES  (QB),
        .RESET_PC(64'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: valid bytes are exactly the addresses [m_head, m_end).
    logic [63:0] m_head;
    logic [63:0] m_end;
    bit          m_err;
    int          epoch;

    // Memory: one outstanding read, tagged with the redirect epoch.
    bit          pend;
    logic [63:0] pend_addr;
    int          pend_due;
    int          pend_epoch;
    int          lat;
    bit          err_en;
    logic [63:0] err_addr;

    int          req_cnt;
    int          proto_bad;
    int          last_err_cyc;
    logic [63:0] req_log[$];

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return (a[7:0] * 8'd13) ^ a[15:8] ^ 8'h5a;
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
        return w;
    endfunction

    function automatic int exp_avail();
        logic [63:0] d;
        d = m_end - m_head;
        if (d >= 64'd10) return 10;
        return int'(d);
    endfunction

    function automatic logic [79:0] exp_mask();
        logic [79:0] m;
        m = '0;
        for (int k = 0; k < exp_avail(); k++) m[8*k +: 8] = 8'hff;
        return m;
    endfunction

    function automatic logic [79:0] exp_bytes();
        logic [79:0] b;
        b = '0;
        for (int k = 0; k < exp_avail(); k++) b[8*k +: 8] = mem_byte(m_head + 64'(k));
        return b;
    endfunction

    // Advance one cycle: called and returns at a negedge.
    task automatic tick();
        bit          resp;
        bit          rerr;
        logic [63:0] raddr;
        int          repoch;
        logic [63:0] cnt;
        resp   = 0;
        rerr   = 0;
        raddr  = '0;
        repoch = 0;
        if (bus.imem_req === 1'b1) begin
            req_cnt++;
            req_log.push_back(bus.imem_addr);
            if (pend || m_err
                || bus.imem_addr !== {m_end[63:3], 3'b000}
                || (m_end - m_head) > 64'(QB - 8)) proto_bad++;
            pend       = 1;
            pend_addr  = bus.imem_addr;
            pend_due   = cyc + lat;
            pend_epoch = epoch;
        end
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = {$urandom, $urandom};
        bus.imem_err    = 1'b0;
        if (pend && cyc >= pend_due) begin
            resp   = 1;
            raddr  = pend_addr;
            repoch = pend_epoch;
            rerr   = err_en && (pend_addr == err_addr);
            pend   = 0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(raddr);
            bus.imem_err    = rerr;
        end
        cnt = m_end - m_head;
        if (bus.redirect) begin
            m_head = bus.redirect_pc;
            m_end  = bus.redirect_pc;
            m_err  = 0;
            epoch++;
        end else begin
            if (bus.consume && bus.consume_len != 4'd0 && bus.consume_len <= 4'd10
                && 64'(bus.consume_len) <= cnt)
                m_head = m_head + 64'(bus.consume_len);
            if (resp && repoch == epoch) begin
                if (rerr) begin
                    m_err        = 1;
                    last_err_cyc = cyc;
                end else begin
                    m_end = raddr + 64'd8;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        bus.redirect    = 1'b0;
        bus.consume     = 1'b0;
        bus.consume_len = 4'd0;
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        tick();
        req_log.delete();
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.imem_err    = 1'b0;
        bus.consume     = 1'b0;
        bus.consume_len = 4'd0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.imem_req !== 1'b0) begin
            bad++; $display("FAIL reset_req got=%0b want=0", bus.imem_req);
        end
        total++;
        if (bus.imem_addr !== 64'h0) begin
            bad++; $display("FAIL reset_addr got=%0h want=0", bus.imem_addr);
        end
        total++;
        if (bus.inst_err !== 1'b0) begin
            bad++; $display("FAIL reset_err got=%0b want=0", bus.inst_err);
        end
        total++;
        if (bus.avail !== 4'd0) begin
            bad++; $display("FAIL reset_avail got=%0d want=0", bus.avail);
        end
        total++;
        if (bus.head_pc !== 64'h0) begin
            bad++; $display("FAIL reset_head got=%0h want=0", bus.head_pc);
        end
        m_head = '0; m_end = '0; m_err = 0; epoch = 0;
        pend = 0; lat = 1; err_en = 0; err_addr = '0;
        req_cnt = 0; proto_bad = 0; last_err_cyc = -10;
        req_log.delete();
        reset = 1'b0;
    endtask

    task automatic test_fill();
        int first_av;
        first_av = -1;
        lat = 1;
        repeat (12) begin
            tick();
            if (first_av < 0 && bus.avail != 4'd0) first_av = int'(bus.avail);
        end
        total++;
        if (req_cnt != 2) begin
            bad++; $display("FAIL fill_req_count got=%0d want=2", req_cnt);
        end
        total++;
        if (req_log.size() < 2 || req_log[0] !== 64'h0 || req_log[1] !== 64'h8) begin
            bad++; $display("FAIL fill_req_addrs got=%p want=0,8", req_log);
        end
        total++;
        if (first_av != 8) begin
            bad++; $display("FAIL fill_first_avail got=%0d want=8", first_av);
        end
        total++;
        if (bus.avail !== 4'd10 || bus.head_pc !== 64'h0) begin
            bad++; $display("FAIL fill_full got=%0d/%0h want=10/0", bus.avail, bus.head_pc);
        end
        total++;
        if ((bus.inst_bytes & exp_mask()) !== exp_bytes()) begin
            bad++; $display("FAIL fill_bytes got=%0h want=%0h", bus.inst_bytes, exp_bytes());
        end
    endtask

    task automatic test_redirect_idle();
        logic [63:0] a;
        do_redirect(64'h13);
        total++;
        if (bus.head_pc !== 64'h13 || bus.avail !== 4'd0) begin
            bad++; $display("FAIL redir_idle_head got=%0h/%0d want=13/0", bus.head_pc, bus.avail);
        end
        for (int i = 0; i < 8 && req_log.size() == 0; i++) tick();
        a = (req_log.size() > 0) ? req_log[0] : '1;
        total++;
        if (a !== 64'h10) begin
            bad++; $display("FAIL redir_idle_addr got=%0h want=10", a);
        end
        repeat (2) tick();
        total++;
        if (bus.avail !== 4'd5) begin
            bad++; $display("FAIL redir_idle_avail got=%0d want=5", bus.avail);
        end
        total++;
        if (bus.inst_bytes[7:0] !== mem_byte(64'h13) || bus.head_pc !== 64'h13) begin
            bad++; $display("FAIL redir_idle_byte got=%0h want=%0h", bus.inst_bytes[7:0], mem_byte(64'h13));
        end
    endtask

    task automatic test_redirect_wait();
        logic [63:0] a;
        int          max_av;
        lat = 3;
        do_redirect(64'h8);
        for (int i = 0; i < 10 && req_log.size() == 0; i++) tick();
        a = (req_log.size() > 0) ? req_log[0] : '1;
        total++;
        if (a !== 64'h8) begin
            bad++; $display("FAIL redir_wait_first got=%0h want=8", a);
        end
        do_redirect(64'h40);
        max_av = 0;
        for (int i = 0; i < 12 && req_log.size() == 0; i++) begin
            tick();
            if (int'(bus.avail) > max_av) max_av = int'(bus.avail);
        end
        total++;
        if (max_av != 0) begin
            bad++; $display("FAIL redir_wait_drop got=%0d want=0", max_av);
        end
        a = (req_log.size() > 0) ? req_log[0] : '1;
        total++;
        if (a !== 64'h40 || bus.head_pc !== 64'h40) begin
            bad++; $display("FAIL redir_wait_addr got=%0h/%0h want=40/40", a, bus.head_pc);
        end
        repeat (5) tick();
        total++;
        if (bus.avail !== 4'd8 || (bus.inst_bytes & exp_mask()) !== exp_bytes()) begin
            bad++; $display("FAIL redir_wait_fill got=%0d want=8", bus.avail);
        end
    endtask

    task automatic test_steady_stream();
        int n_cons;
        int nb;
        n_cons = 0;
        nb     = 0;
        lat    = 1;
        do_redirect(64'h100);
        repeat (80) begin
            if (bus.avail == 4'd10) begin
                bus.consume     = 1'b1;
                bus.consume_len = 4'd10;
                n_cons++;
            end
            tick();
            if (bus.head_pc !== m_head || (bus.inst_bytes & exp_mask()) !== exp_bytes()
                || int'(bus.avail) != exp_avail()) nb++;
        end
        total++;
        if (nb != 0) begin
            bad++; $display("FAIL stream_cycles got=%0d want=0", nb);
        end
        total++;
        if (n_cons < 3 || bus.head_pc !== 64'h100 + 64'(10 * n_cons)) begin
            bad++; $display("FAIL stream_head got=%0h want=%0h", bus.head_pc, 64'h100 + 64'(10 * n_cons));
        end
    endtask

    task automatic test_partial_consume();
        bit hit;
        hit = 0;
        lat = 3;
        do_redirect(64'h204);
        for (int i = 0; i < 20 && bus.avail != 4'd4; i++) tick();
        total++;
        if (bus.avail !== 4'd4) begin
            bad++; $display("FAIL part_avail4 got=%0d want=4", bus.avail);
        end
        bus.consume     = 1'b1;
        bus.consume_len = 4'd6;
        tick();
        total++;
        if (bus.head_pc !== 64'h204 || bus.avail !== 4'd4) begin
            bad++; $display("FAIL part_ignore got=%0h/%0d want=204/4", bus.head_pc, bus.avail);
        end
        for (int i = 0; i < 10 && !hit; i++) begin
            if (pend && cyc >= pend_due) begin
                bus.consume     = 1'b1;
                bus.consume_len = 4'd3;
                hit = 1;
            end
            tick();
        end
        total++;
        if (!hit || bus.avail !== 4'd9 || bus.head_pc !== 64'h207) begin
            bad++; $display("FAIL part_merge got=%0d/%0h want=9/207", bus.avail, bus.head_pc);
        end
        total++;
        if (bus.inst_bytes[7:0] !== mem_byte(64'h207)) begin
            bad++; $display("FAIL part_byte got=%0h want=%0h", bus.inst_bytes[7:0], mem_byte(64'h207));
        end
    endtask

    task automatic test_fetch_error();
        int          n;
        logic [63:0] a;
        lat      = 1;
        err_en   = 1;
        err_addr = 64'h18;
        do_redirect(64'h10);
        for (int i = 0; i < 20 && bus.inst_err !== 1'b1; i++) tick();
        total++;
        if (bus.inst_err !== 1'b1 || cyc != last_err_cyc + 1) begin
            bad++; $display("FAIL err_set got=%0b@%0d want=1@%0d", bus.inst_err, cyc, last_err_cyc + 1);
        end
        n = req_cnt;
        repeat (10) tick();
        total++;
        if (req_cnt != n || bus.inst_err !== 1'b1) begin
            bad++; $display("FAIL err_block got=%0d want=%0d", req_cnt, n);
        end
        total++;
        if (bus.avail !== 4'd8 || bus.head_pc !== 64'h10) begin
            bad++; $display("FAIL err_keep got=%0d/%0h want=8/10", bus.avail, bus.head_pc);
        end
        err_en = 0;
        do_redirect(64'h0);
        total++;
        if (bus.inst_err !== 1'b0) begin
            bad++; $display("FAIL err_clear got=%0b want=0", bus.inst_err);
        end
        for (int i = 0; i < 8 && req_log.size() == 0; i++) tick();
        a = (req_log.size() > 0) ? req_log[0] : '1;
        total++;
        if (a !== 64'h0) begin
            bad++; $display("FAIL err_resume got=%0h want=0", a);
        end
    endtask

    task automatic test_random();
        err_en   = 1;
        err_addr = 64'h58;
        repeat (500) begin
            if ($urandom_range(0, 19) == 0) begin
                bus.redirect = 1'b1;
                if ($urandom_range(0, 7) == 0)
                    bus.redirect_pc = 64'hffff_ffff_ffff_fff0 + 64'($urandom_range(0, 15));
                else
                    bus.redirect_pc = 64'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 2) != 0) begin
                bus.consume     = 1'b1;
                bus.consume_len = 4'($urandom_range(0, 12));
            end
            lat = $urandom_range(1, 4);
            tick();
            total++;
            if (bus.head_pc !== m_head) begin
                bad++; $display("FAIL rand_head got=%0h want=%0h", bus.head_pc, m_head);
            end
            total++;
            if (int'(bus.avail) != exp_avail()) begin
                bad++; $display("FAIL rand_avail got=%0d want=%0d", bus.avail, exp_avail());
            end
            total++;
            if (bus.inst_err !== m_err) begin
                bad++; $display("FAIL rand_err got=%0b want=%0b", bus.inst_err, m_err);
            end
            total++;
            if ((bus.inst_bytes & exp_mask()) !== exp_bytes()) begin
                bad++; $display("FAIL rand_bytes got=%0h want=%0h", bus.inst_bytes & exp_mask(), exp_bytes());
            end
        end
        total++;
        if (proto_bad != 0) begin
            bad++; $display("FAIL req_protocol got=%0d want=0", proto_bad);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_redirect_idle();
        test_redirect_wait();
        test_steady_stream();
        test_partial_consume();
        test_fetch_error();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Byte-stream instruction prefetcher sitting directly upstream of the fetch stage.
- Issues 8-byte-aligned reads to instruction memory and buffers the returned bytes.
- Presents up to 10 contiguous bytes starting at head_pc, so fetch can decode any instruction without touching memory.
- Flushed and restarted on PC redirect: mispredicted jXX, ret resolution.

Parameters:
- QBYTES, 16, queue capacity in bytes; power of two, >= 16.
- RESET_PC, 0, fetch start address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect  in  1  flush queue and restart fetching at redirect_pc.
- redirect_pc  in  64  new head PC (any byte alignment).
- imem_req  out  1  single-cycle read request pulse.
- imem_addr  out  64  request address; bits [2:0] always 0.
- imem_rvalid  in  1  response valid; exactly one per request, >=1 cycle after imem_req.
- imem_rdata  in  64  response data; byte at address A+i is on bits [8i+7:8i].
- imem_err  in  1  response fault, qualified by imem_rvalid.
- inst_bytes  out  80  head bytes; byte at head_pc on bits [7:0]; bytes beyond avail are don't-care.
- avail  out  4  number of valid head bytes, min(count,10).
- head_pc  out  64  address of inst_bytes byte 0.
- consume  in  1  fetch dequeues consume_len bytes this cycle.
- consume_len  in  4  1..10 bytes.
- inst_err  out  1  sticky fetch fault: no further bytes will arrive until redirect.

Behaviour:
- Reset values (asynchronous):
  - count=0, head_pc=RESET_PC, fetch_addr=RESET_PC & ~7, drop_off=RESET_PC[2:0], state=IDLE.
  - imem_req=0, imem_addr=0, inst_err=0, avail=0.
- State IDLE:
  - If no redirect and err=0 and (count + bytes_in_flight_reserve) <= QBYTES-8: pulse imem_req=1 with imem_addr=fetch_addr, then go to WAIT.
  - Space is checked against count after this cycle's consume; reserving 8 bytes guarantees the response always fits.
- State WAIT, on imem_rvalid:
  - If imem_err: set err and return to IDLE; err blocks all further requests.
  - Otherwise write bytes drop_off..7 at queue tail, count += 8-drop_off, drop_off=0, fetch_addr += 8, return to IDLE.
  - A request may be issued again on the cycle after rvalid.
- State DROP:
  - Entered when redirect arrives during WAIT; the next imem_rvalid is discarded (data and err), then go to IDLE.
  - A further redirect while in DROP stays in DROP and updates the restart address.
- Redirect (highest priority; overrides same-cycle consume and response write):
  - count=0, err=0, head_pc=redirect_pc, fetch_addr=redirect_pc & ~7, drop_off=redirect_pc[2:0].
  - State becomes DROP if a request is outstanding (WAIT, or rvalid not yet returned), else IDLE.
  - imem_req is 0 in the redirect cycle; the first new request issues the following cycle at the earliest.
- Consume:
  - When consume && consume_len <= avail && !redirect: head advances; head_pc += consume_len; count -= consume_len.
  - consume_len > avail or consume_len==0: entire consume ignored (no state change).
  - Consume and response write in the same cycle are both applied: count = count - consume_len + written.
- Outputs inst_bytes, avail and head_pc are registered state; data written on rvalid is visible the next cycle.
- Circular buffer: head/tail pointers wrap modulo QBYTES; count never exceeds QBYTES.
- inst_err = err; asserted the cycle after the faulting rvalid, held until redirect or reset.
- head_pc and fetch_addr arithmetic is 64-bit with wrap-around modulo 2^64; no special case.
- Reset asserted mid-WAIT: state returns to IDLE immediately. The memory guarantees no stale rvalid after reset.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1, no consume:
  - req at 0x0 then 0x8; avail=8 after the first response, 10 after the second.
  - Third req only after space frees (count 16 > 8): no third request.
- Redirect to 0x13 while idle, memory returns bytes 0x10..0x17:
  - Next cycle imem_addr=0x10.
  - After response: count=5, inst_bytes[7:0]=byte 0x13, head_pc=0x13.
- Redirect to 0x40 during WAIT for 0x8 (latency 3):
  - 0x8 response discarded (avail stays 0).
  - Next req addr=0x40; head_pc=0x40.
- Steady stream, consume_len=10 every cycle avail=10:
  - head_pc advances by 10 per cycle; bytes match memory image across buffer wrap (pointer > 15).
- consume_len=6 with avail=4: ignored, head_pc unchanged. Then consume 3 in the same cycle as an 8-byte response: count=4-3+8=9.
- imem_err on the response for 0x18: inst_err=1 next cycle; no further imem_req; redirect to 0x0 clears inst_err and resumes fetching at 0x0.
